// File: rtl/button_switch_port_pkg.sv
// Shared CPU I/O definitions for the button/switch port: register map,
// debounce default and the counter sizing helper.
package button_switch_port_pkg;

    localparam int unsigned NUM_BUTTONS  = 4;
    localparam int unsigned NUM_SWITCHES = 10;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ADDR_W       = 2;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

    localparam logic [ADDR_W-1:0] ADDR_BUTTONS = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PENDING = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_SW_LO   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_SW_HI   = 2'd3;

    typedef enum logic [ADDR_W-1:0] {
        REG_BUTTONS = ADDR_BUTTONS,
        REG_PENDING = ADDR_PENDING,
        REG_SW_LO   = ADDR_SW_LO,
        REG_SW_HI   = ADDR_SW_HI
    } reg_addr_e;

    // Counter only ever holds 0..cycles-1, so clog2 bits are enough.
    function automatic int unsigned counter_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_switch_port_if.sv
// CPU-side read bus of the button/switch port.
interface button_switch_port_if;

    logic                                     rd_en;
    logic [button_switch_port_pkg::ADDR_W-1:0] addr;
    logic [button_switch_port_pkg::DATA_W-1:0] rd_data;
    logic                                     irq;

    modport master (
        output rd_en,
        output addr,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  rd_en,
        input  addr,
        output rd_data,
        output irq
    );

endinterface

// File: rtl/button_switch_port_debounce_bit.sv
// debounce_bit: two-flop synchronizer, saturating stability counter,
// stable level and a press strobe for one active-low button.
module button_switch_port_debounce_bit
    import button_switch_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int unsigned      CNT_W    = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] count_reg;

    logic differ;
    logic accept;

    assign differ = (sync_reg != stable_reg);
    // The edge on which the counter would reach DEBOUNCE_CYCLES.
    assign accept = differ && (count_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_reg   <= 1'b1;
            sync_reg   <= 1'b1;
            stable_reg <= 1'b1;
            count_reg  <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            if (!differ) begin
                count_reg <= '0;
            end else if (accept) begin
                stable_reg <= sync_reg;
                count_reg  <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign stable = stable_reg;
    // Driven only from registers, so the press lands on the same edge the
    // stable level falls without any input-to-output path.
    assign press  = accept && !sync_reg;

endmodule

// File: rtl/button_switch_port.sv
// Memory-mapped button/switch port: debounced buttons with sticky press
// flags and interrupt, synchronized switches, registered CPU read.
module button_switch_port
    import button_switch_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  buttons,
    input  logic [NUM_SWITCHES-1:0] switches,
    button_switch_port_if.slave     bus
);

    logic [NUM_BUTTONS-1:0]  stable;
    logic [NUM_BUTTONS-1:0]  press;

    logic [NUM_SWITCHES-1:0] sw_meta_reg;
    logic [NUM_SWITCHES-1:0] sw_sync_reg;

    logic [NUM_BUTTONS-1:0]  pending_reg;
    logic [NUM_BUTTONS-1:0]  pending_next;
    logic [NUM_BUTTONS-1:0]  clear_mask;
    logic [DATA_W-1:0]       rd_data_reg;
    logic [DATA_W-1:0]       rd_data_next;
    logic                    irq_reg;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            button_switch_port_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce_bit (
                .clk    (clk),
                .reset  (reset),
                .raw    (buttons[gi]),
                .stable (stable[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    // Clear only what the CPU is handed; a press on the same edge wins.
    always_comb begin
        clear_mask = '0;
        if (bus.rd_en && (bus.addr == ADDR_PENDING)) begin
            clear_mask = pending_reg;
        end
        pending_next = (pending_reg & ~clear_mask) | press;
    end

    always_comb begin
        rd_data_next = rd_data_reg;
        if (bus.rd_en) begin
            case (reg_addr_e'(bus.addr))
                REG_BUTTONS: rd_data_next = {{(DATA_W-NUM_BUTTONS){1'b0}}, ~stable};
                REG_PENDING: rd_data_next = {{(DATA_W-NUM_BUTTONS){1'b0}}, pending_reg};
                REG_SW_LO:   rd_data_next = sw_sync_reg[DATA_W-1:0];
                REG_SW_HI:   rd_data_next = {{(2*DATA_W-NUM_SWITCHES){1'b0}},
                                             sw_sync_reg[NUM_SWITCHES-1:DATA_W]};
                default:     rd_data_next = rd_data_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            pending_reg <= '0;
            rd_data_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            sw_meta_reg <= switches;
            sw_sync_reg <= sw_meta_reg;
            pending_reg <= pending_next;
            rd_data_reg <= rd_data_next;
            irq_reg     <= |pending_reg;
        end
    end

    assign bus.rd_data = rd_data_reg;
    assign bus.irq     = irq_reg;

endmodule

// File: doc/button_switch_port.md
BUTTON_SWITCH_PORT -- requirements
Module: button_switch_port

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a button change; legal range 2..65535.
REQ-002 clk  input  1  system clock, all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 buttons  input  4  raw push buttons, active-low (1111 = none pressed), asynchronous to clk.
REQ-005 switches  input  10  raw slide switches, asynchronous to clk.
REQ-006 rd_en  input  1  CPU read strobe, one cycle per read.
REQ-007 addr  input  2  register select for the read.
REQ-008 rd_data  output  8  registered read data.
REQ-009 irq  output  1  high while any press is pending.

Function
REQ-010 buttons and switches SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 Each button SHALL have an independent debouncer holding a stable level and a saturating counter.
REQ-012 Counter SHALL clear whenever the synchronized input equals the stable level.
REQ-013 Counter SHALL increment while they differ; on the edge where it would reach DEBOUNCE_CYCLES, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the stable level.
REQ-015 A stable 1->0 transition (press) SHALL set that button's pending bit in the same cycle the stable level changes; raw edge to pending = DEBOUNCE_CYCLES+2 cycles.
REQ-016 Releases (0->1) SHALL NOT set or clear pending.
REQ-017 Register map, read-only: addr 0 = {4'b0, ~stable_buttons}; addr 1 = {4'b0, pending}; addr 2 = synchronized switches[7:0]; addr 3 = {6'b0, synchronized switches[9:8]}.
REQ-018 rd_data SHALL update on the clk edge where rd_en=1 (visible one cycle after the strobe) and SHALL hold its value when rd_en=0.
REQ-019 A read of addr 1 SHALL clear exactly the pending bits returned in rd_data.
REQ-020 A press on the same edge as an addr-1 read SHALL leave that bit set after the read (set wins over clear); the returned value SHALL be the pre-edge pending.
REQ-021 Reads of addr 0, 2 and 3 SHALL have no side effects.
REQ-022 irq SHALL be registered and equal the OR of pending after each edge (one cycle after pending changes).
REQ-023 A second press of an already-pending button SHALL leave pending at 1 (no counting).

Reset
REQ-024 While reset=0 at a clk edge: button synchronizers and stable levels = 1111, switch synchronizers = 0, counters = 0, pending = 0000, rd_data = 8'h00, irq = 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; a button held low through reset release SHALL register as a press DEBOUNCE_CYCLES+2 cycles after release.
REQ-026 Reads with rd_en=1 during reset SHALL be ignored.

Structure
REQ-027 The four register address constants and the DEBOUNCE_CYCLES default SHALL live in the shared CPU I/O definitions package/header used by entorno_cpu.
REQ-028 Counter width SHALL be derived from DEBOUNCE_CYCLES (clog2).
REQ-029 One sub-module, debounce_bit (sync, counter, stable level, press pulse), SHALL be instantiated four times.
REQ-030 No latches and no combinational path from any input to rd_data or irq.

Verification (DEBOUNCE_CYCLES=4, 60 ns clock)
REQ-031 Reset, buttons=1111, switches=10'b0001000001; read addr 2 then addr 3 -> rd_data 8'h41 then 8'h00; irq=0.
REQ-032 buttons 1111->1110 held -> pending=0001 exactly 6 cycles after the edge, irq=1 on the next cycle; read addr 0 -> 8'h01.
REQ-033 Pulse buttons[1] low for 3 cycles -> pending and stable levels unchanged; addr 1 read -> 8'h00.
REQ-034 pending=0001, read addr 1 -> rd_data 8'h01, pending 0000, irq low one cycle later; second read -> 8'h00.
REQ-035 Read addr 1 on the edge where button 2's press lands, with pending=0001 -> rd_data 8'h01, pending afterwards 0100, irq stays 1.
REQ-036 Hold button 3 low, pulse reset low mid-count, keep button low -> pending=1000 six cycles after reset deasserts; no earlier.
